// File: rtl/mask_pwm_mod.sv
// M-ASK pulse modulator: splits buffered sample words into BPS-bit symbols, MSB first,
// and drives the selected amplitude channel with a free-running square carrier.
module mask_pwm_mod #(
    parameter int SAMPLE_W = 8,
    parameter int BPS      = 2,
    parameter int SYM_DIV  = 62500,
    parameter int CAR_DIV  = 250,
    parameter int GRAY     = 0,
    localparam int NCH     = 2 ** BPS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [SAMPLE_W-1:0] s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic [NCH-1:0]      lvl_o,
    output logic [NCH-1:0]      lvl_oe,
    output logic [BPS-1:0]      sym_o,
    output logic                busy,
    output logic                underrun
);

    localparam int NSYM = SAMPLE_W / BPS;
    localparam int SW   = (NSYM > 1) ? $clog2(NSYM) : 1;
    localparam int PW   = $clog2(SYM_DIV);
    localparam int CW   = (CAR_DIV > 1) ? $clog2(CAR_DIV) : 1;

    typedef enum logic [0:0] {S_IDLE, S_RUN} state_t;

    state_t              state_q, state_d;
    logic [SAMPLE_W-1:0] hold_q, hold_d;
    logic                hold_full_q, hold_full_d;
    logic [SAMPLE_W-1:0] shreg_q, shreg_d;
    logic [SW-1:0]       scnt_q, scnt_d;
    logic [PW-1:0]       pcnt_q, pcnt_d;
    logic [CW-1:0]       ccnt_q, ccnt_d;
    logic                car_q, car_d;
    logic [NCH-1:0]      lvl_o_q, lvl_o_d;
    logic [NCH-1:0]      lvl_oe_q, lvl_oe_d;
    logic [BPS-1:0]      sym_o_q, sym_o_d;
    logic                underrun_q, underrun_d;

    logic                tick;
    logic [BPS-1:0]      sym_raw;
    logic [BPS-1:0]      sym_sel;
    logic [NCH-1:0]      onehot;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shreg_d     = shreg_q;
        scnt_d      = scnt_q;
        pcnt_d      = pcnt_q;
        ccnt_d      = ccnt_q;
        car_d       = car_q;
        underrun_d  = 1'b0;
        sym_sel     = '0;

        if (s_valid && !hold_full_q) begin
            hold_d      = s_data;
            hold_full_d = 1'b1;
        end

        // Carrier keeps running across state changes; only en freezes it.
        if (en) begin
            if (ccnt_q == CW'(CAR_DIV - 1)) begin
                ccnt_d = '0;
                car_d  = ~car_q;
            end else begin
                ccnt_d = ccnt_q + CW'(1);
            end
        end

        tick = (state_q == S_RUN) && en && (pcnt_q == PW'(SYM_DIV - 1));

        case (state_q)
            S_IDLE: begin
                if (en && hold_full_q) begin
                    state_d     = S_RUN;
                    shreg_d     = hold_q;
                    hold_full_d = 1'b0;
                    scnt_d      = '0;
                    pcnt_d      = '0;
                end
            end
            S_RUN: begin
                if (en) begin
                    if (!tick) begin
                        pcnt_d = pcnt_q + PW'(1);
                    end else begin
                        pcnt_d = '0;
                        if (scnt_q != SW'(NSYM - 1)) begin
                            shreg_d = shreg_q << BPS;
                            scnt_d  = scnt_q + SW'(1);
                        end else if (hold_full_q) begin
                            // Seamless reload: the next word starts on the very next symbol slot.
                            shreg_d     = hold_q;
                            hold_full_d = 1'b0;
                            scnt_d      = '0;
                        end else begin
                            state_d    = S_IDLE;
                            underrun_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        sym_raw = shreg_q[SAMPLE_W-1 -: BPS];
        if (GRAY != 0) begin
            for (int i = 0; i < BPS; i++) begin
                sym_sel[i] = ^(sym_raw >> i);
            end
        end else begin
            sym_sel = sym_raw;
        end
        onehot = NCH'(1) << sym_sel;

        lvl_oe_d = '0;
        lvl_o_d  = '0;
        sym_o_d  = '0;
        if (state_q == S_RUN) begin
            sym_o_d = sym_sel;
            if (en) begin
                lvl_oe_d = onehot;
                lvl_o_d  = onehot & {NCH{car_q}};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shreg_q     <= '0;
            scnt_q      <= '0;
            pcnt_q      <= '0;
            ccnt_q      <= '0;
            car_q       <= 1'b0;
            lvl_o_q     <= '0;
            lvl_oe_q    <= '0;
            sym_o_q     <= '0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shreg_q     <= shreg_d;
            scnt_q      <= scnt_d;
            pcnt_q      <= pcnt_d;
            ccnt_q      <= ccnt_d;
            car_q       <= car_d;
            lvl_o_q     <= lvl_o_d;
            lvl_oe_q    <= lvl_oe_d;
            sym_o_q     <= sym_o_d;
            underrun_q  <= underrun_d;
        end
    end

    assign s_ready  = ~hold_full_q;
    assign busy     = (state_q == S_RUN);
    assign lvl_o    = lvl_o_q;
    assign lvl_oe   = lvl_oe_q;
    assign sym_o    = sym_o_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_mask_pwm_mod.sv
// Bench for mask_pwm_mod: directed words, run-length scoreboard on lvl_oe/lvl_o,
// underrun events, and a Gray-mode instance checked on sym_o.
module tb_mask_pwm_mod;

    localparam int IW = 22;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b1;
    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0;

    logic       s_ready, busy, underrun;
    logic [3:0] lvl_o, lvl_oe;
    logic [1:0] sym_o;
    logic       s_ready_g, busy_g, underrun_g;
    logic [3:0] lvl_o_g, lvl_oe_g;
    logic [1:0] sym_o_g;

    int n_cmp = 0;
    int n_err = 0;
    bit gray_on = 1'b0;

    // item: {kind, oe[3:0], len[7:0], hi[7:0], leak}; kind=1 marks an underrun pulse
    logic [IW-1:0] exp_q[$];
    logic [9:0]    exp_g_q[$];

    mask_pwm_mod #(.SAMPLE_W(8), .BPS(2), .SYM_DIV(8), .CAR_DIV(2), .GRAY(0)) u_dut (
        .clk(clk), .rst(rst), .en(en), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .lvl_o(lvl_o), .lvl_oe(lvl_oe), .sym_o(sym_o),
        .busy(busy), .underrun(underrun)
    );

    mask_pwm_mod #(.SAMPLE_W(8), .BPS(2), .SYM_DIV(8), .CAR_DIV(2), .GRAY(1)) u_gray (
        .clk(clk), .rst(rst), .en(en), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready_g), .lvl_o(lvl_o_g), .lvl_oe(lvl_oe_g), .sym_o(sym_o_g),
        .busy(busy_g), .underrun(underrun_g)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_run(input logic [3:0] v, input int len, input int hi);
        exp_q.push_back({1'b0, v, 8'(len), 8'(hi), 1'b0});
    endtask

    task automatic push_urun();
        exp_q.push_back({1'b1, 21'b0});
    endtask

    task automatic score(input logic [IW-1:0] act);
        logic [IW-1:0] e;
        logic [IW-1:0] m;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL lvl_unexpected: got kind=%0d oe=%b len=%0d hi=%0d expected nothing",
                     act[21], act[20:17], act[16:9], act[8:1]);
        end else begin
            e = exp_q.pop_front();
            m = '1;
            if (e[8:1] == 8'hFF) m[8:1] = '0;
            if ((act & m) !== (e & m)) begin
                n_err++;
                $display("FAIL lvl_run: got kind=%0d oe=%b len=%0d hi=%0d leak=%0d expected kind=%0d oe=%b len=%0d hi=%0d leak=%0d",
                         act[21], act[20:17], act[16:9], act[8:1], act[0],
                         e[21], e[20:17], e[16:9], e[8:1], e[0]);
            end
        end
    endtask

    task automatic score_g(input logic [9:0] act);
        logic [9:0] e;
        n_cmp++;
        if (exp_g_q.size() == 0) begin
            n_err++;
            $display("FAIL gray_unexpected: got sym=%0d len=%0d expected nothing", act[9:8], act[7:0]);
        end else begin
            e = exp_g_q.pop_front();
            if (act !== e) begin
                n_err++;
                $display("FAIL gray_run: got sym=%0d len=%0d expected sym=%0d len=%0d",
                         act[9:8], act[7:0], e[9:8], e[7:0]);
            end
        end
    endtask

    // Main monitor: compresses lvl_oe into runs; zero runs count only while busy throughout.
    initial begin
        logic [3:0] cur_v;
        int cur_len, cur_hi;
        bit cur_leak, cur_busy;
        cur_v = '0; cur_len = 0; cur_hi = 0; cur_leak = 1'b0; cur_busy = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst) begin
                cur_v = '0; cur_len = 0; cur_hi = 0; cur_leak = 1'b0; cur_busy = 1'b1;
            end else begin
                if (lvl_oe !== cur_v) begin
                    if (cur_len > 0 && (cur_v != 4'd0 || cur_busy))
                        score({1'b0, cur_v, 8'(cur_len), 8'(cur_hi), cur_leak});
                    cur_v = lvl_oe; cur_len = 0; cur_hi = 0; cur_leak = 1'b0; cur_busy = 1'b1;
                end
                cur_len++;
                if ((lvl_o & lvl_oe) != 4'd0) cur_hi++;
                if ((lvl_o & ~lvl_oe) != 4'd0) cur_leak = 1'b1;
                cur_busy = cur_busy & busy;
                if (underrun) score({1'b1, 21'b0});
            end
        end
    end

    // Gray monitor: runs of sym_o while the Gray instance drives a channel.
    initial begin
        logic [2:0] g_key, g_cur;
        int g_len;
        g_cur = '0; g_len = 0;
        forever begin
            @(negedge clk);
            if (!rst || !gray_on) begin
                g_cur = '0; g_len = 0;
            end else begin
                g_key = (lvl_oe_g != 4'd0) ? {1'b1, sym_o_g} : 3'b000;
                if (g_key != g_cur) begin
                    if (g_cur[2] && g_len > 0) score_g({g_cur[1:0], 8'(g_len)});
                    g_cur = g_key; g_len = 0;
                end
                g_len++;
            end
        end
    end

    task automatic send(input logic [7:0] d);
        bit acc;
        bit done;
        done = 1'b0;
        s_data = d;
        s_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            acc = s_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                done = 1'b1;
                break;
            end
        end
        s_valid = 1'b0;
        check("send_accept", 32'(done), 32'd1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0 && exp_g_q.size() == 0) break;
            @(posedge clk);
        end
        check("done_timeout", 32'(exp_q.size() + exp_g_q.size()), 32'd0);
        exp_q.delete();
        exp_g_q.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int bad;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_lvl_o", 32'(lvl_o), 32'd0);
        check("rst_lvl_oe", 32'(lvl_oe), 32'd0);
        check("rst_sym_o", 32'(sym_o), 32'd0);
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (!s_ready || busy || lvl_oe != 4'd0 || underrun) bad++;
        end
        check("idle_quiet_cycles", 32'(bad), 32'd0);

        // Single word 0x1B: symbols 0,1,2,3
        push_run(4'b0001, 8, 4);
        push_run(4'b0010, 8, 4);
        push_run(4'b0100, 8, 4);
        push_urun();
        push_run(4'b1000, 8, 4);
        send(8'h1B);
        wait_done();
        check("single_busy_end", 32'(busy), 32'd0);

        // Back-to-back 0xE4 then 0x1B: the two 0001 symbols merge into one 16-cycle run
        push_run(4'b1000, 8, 4);
        push_run(4'b0100, 8, 4);
        push_run(4'b0010, 8, 4);
        push_run(4'b0001, 16, 8);
        push_run(4'b0010, 8, 4);
        push_run(4'b0100, 8, 4);
        push_urun();
        push_run(4'b1000, 8, 4);
        send(8'hE4);
        send(8'h1B);
        wait_done();
        check("b2b_s_ready_end", 32'(s_ready), 32'd1);

        // Gray mode 0x2D: raw 0,2,3,1 -> decoded 0,3,2,1
        gray_on = 1'b1;
        push_run(4'b0001, 8, 4);
        push_run(4'b0100, 8, 4);
        push_run(4'b1000, 8, 4);
        push_urun();
        push_run(4'b0010, 8, 4);
        exp_g_q.push_back({2'd0, 8'd8});
        exp_g_q.push_back({2'd3, 8'd8});
        exp_g_q.push_back({2'd2, 8'd8});
        exp_g_q.push_back({2'd1, 8'd8});
        send(8'h2D);
        wait_done();
        gray_on = 1'b0;

        // Enable pause of 20 cycles after 3 cycles of symbol 1
        push_run(4'b0001, 8, 4);
        push_run(4'b0010, 3, 255);
        push_run(4'b0000, 20, 0);
        push_run(4'b0010, 5, 255);
        push_run(4'b0100, 8, 4);
        push_urun();
        push_run(4'b1000, 8, 4);
        send(8'h1B);
        repeat (12) @(posedge clk);
        #1;
        en = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        en = 1'b1;
        wait_done();

        // Reset during symbol 2 with a second word held
        push_run(4'b0001, 8, 4);
        push_run(4'b0010, 8, 4);
        send(8'h1B);
        send(8'hE4);
        repeat (18) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_s_ready", 32'(s_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_underrun", 32'(underrun), 32'd0);
        check("midrst_lvl_o", 32'(lvl_o), 32'd0);
        check("midrst_lvl_oe", 32'(lvl_oe), 32'd0);
        check("midrst_sym_o", 32'(sym_o), 32'd0);
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (busy || lvl_oe != 4'd0 || underrun || !s_ready) bad++;
        end
        check("post_rst_quiet_cycles", 32'(bad), 32'd0);
        check("post_rst_pending", 32'(exp_q.size()), 32'd0);

        // Recovery with a fresh word
        push_run(4'b1000, 8, 4);
        push_run(4'b0100, 8, 4);
        push_run(4'b0010, 8, 4);
        push_urun();
        push_run(4'b0001, 8, 4);
        send(8'hE4);
        wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

endmodule
